lsu_unit: RTL and testbench

//  Load/store stage directly downstream of the ALU stage. Consumes the ALU sum (effective address) plus rs2 data.

---
 rtl/lsu_unit_pkg.sv | 37 +++
 rtl/lsu_unit_align.sv | 50 +++++
 rtl/lsu_unit.sv | 129 ++++++++++++
 tb/tb_lsu_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_unit_pkg.sv
`default_nettype none
// lsu_unit_pkg: shared encodings for the load/store unit and its lane aligner.
// Revision 1.0
package lsu_unit_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_SIZE    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } lsu_err_e;

  // Misaligned halves/words and the reserved size never reach memory.
  function automatic logic lsu_illegal(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_unit_align.sv
`default_nettype none
// lsu_unit_align: store byte-lane replication/mask and load lane extract/extend.
// Revision 1.0
module lsu_unit_align
  import lsu_unit_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  input  logic [1:0]  ld_size,
  input  logic        ld_uns,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_data,
  output logic [31:0] ld_result
);

  logic [15:0] lane;

  always_comb begin
    st_wdata = st_data;
    st_wmask = 4'b0000;
    case (st_size)
      SZ_B: begin
        st_wmask = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_wmask = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      SZ_W:    st_wmask = 4'b1111;
      default: st_wmask = 4'b0000;
    endcase
  end

  always_comb begin
    lane      = 16'(ld_data >> {ld_off, 3'b000});
    ld_result = '0;
    case (ld_size)
      SZ_B:    ld_result = {{24{lane[7] & ~ld_uns}}, lane[7:0]};
      SZ_H:    ld_result = {{16{lane[15] & ~ld_uns}}, lane[15:0]};
      SZ_W:    ld_result = ld_data;
      default: ld_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_unit.sv
`default_nettype none
// lsu_unit: single-outstanding load/store stage between ALU and writeback.
// Revision 1.0
module lsu_unit
  import lsu_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  lsu_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [3:0]       op_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      st_wdata;
  logic [3:0]       st_wmask;
  logic [31:0]      ld_result;
  logic             illegal;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_RESP);
  assign illegal   = lsu_illegal(lsu_op[1:0], addr[1:0]);

  // Store lanes come from the incoming op; load extraction uses the latched op.
  lsu_unit_align u_align (
    .st_size   (lsu_op[1:0]),
    .st_off    (addr[1:0]),
    .st_data   (wdata),
    .st_wdata  (st_wdata),
    .st_wmask  (st_wmask),
    .ld_size   (op_q[1:0]),
    .ld_uns    (op_q[OP_UNS]),
    .ld_off    (off_q),
    .ld_data   (mem_rdata),
    .ld_result (ld_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      off_q     <= '0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      out_rdata <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q      <= lsu_op;
            off_q     <= addr[1:0];
            out_rdata <= '0;
            cnt       <= '0;
            if (illegal) begin
              state   <= ST_RESP;
              out_err <= 1'b1;
            end else begin
              state     <= ST_REQ;
              out_err   <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= lsu_op[OP_STORE];
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= lsu_op[OP_STORE] ? st_wdata : 32'h0;
              mem_wmask <= lsu_op[OP_STORE] ? st_wmask : 4'b0000;
            end
          end
        end
        ST_REQ: begin
          // An ack on the final counted cycle still wins over the timeout.
          if (mem_ack) begin
            state     <= ST_RESP;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= 4'b0000;
            out_rdata <= op_q[OP_STORE] ? 32'h0 : ld_result;
            out_err   <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_RESP;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= 4'b0000;
            out_rdata <= '0;
            out_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_rdata <= '0;
            out_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_unit.sv
`default_nettype none
// tb_lsu_unit: directed and randomized accesses checked against a byte-level reference model.
// Revision 1.0
module tb_lsu_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  lsu_op;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  lsu_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .addr(addr), .wdata(wdata), .lsu_op(lsu_op),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for the reserved encoding.
  function automatic int ref_bytes(input logic [3:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [3:0] op, input logic [31:0] a);
    int n = ref_bytes(op);
    if (n == 0) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [3:0] op, input logic [31:0] a);
    logic [3:0] m = 4'b0000;
    int n = ref_bytes(op);
    int o = int'(a % 4);
    for (int i = 0; i < 4; i++)
      if (i >= o && i < o + n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] wd);
    logic [31:0] r = 32'h0;
    int n = ref_bytes(op);
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    int n = ref_bytes(op);
    int bits = 8 * n;
    logic [31:0] lane = rd >> (8 * (a % 4));
    logic [31:0] lowmask;
    logic [31:0] v;
    if (n == 4) return rd;
    lowmask = (32'h1 << bits) - 1;
    v = lane & lowmask;
    if (!op[2] && v[bits-1]) v = v | ~lowmask;
    return v;
  endfunction

  // One complete access from IDLE back to IDLE; called at a negedge with the DUT idle.
  task automatic access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_dly, input int rdy_dly);
    logic        ill = ref_illegal(op, a);
    logic        tmo = 1'b0;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n = 0;
    check("in_ready_idle", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; lsu_op = op; addr = a; wdata = wd;
    @(negedge clk);
    in_valid = 1'b0; lsu_op = 4'($urandom); addr = $urandom; wdata = $urandom;
    if (ill) begin
      check("illegal_no_req", {31'h0, mem_req}, 32'h0);
    end else begin
      check("req_high", {31'h0, mem_req}, 32'h1);
      check("req_we", {31'h0, mem_we}, {31'h0, op[3]});
      check("req_addr", mem_addr, {a[31:2], 2'b00});
      check("req_wmask", {28'h0, mem_wmask}, op[3] ? {28'h0, ref_mask(op, a)} : 32'h0);
      if (op[3]) check("req_wdata", mem_wdata, ref_wdata(op, wd));
      while (n < ack_dly && n < TIMEOUT) begin
        check("req_hold", {31'h0, mem_req}, 32'h1);
        mem_ack = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b0;
        @(negedge clk);
        n++;
      end
      if (n >= TIMEOUT) begin
        tmo = 1'b1;
        check("timeout_req_low", {31'h0, mem_req}, 32'h0);
      end else begin
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
        check("ack_req_low", {31'h0, mem_req}, 32'h0);
      end
    end
    exp_err = ill | tmo;
    exp_rd  = (exp_err || op[3]) ? 32'h0 : ref_load(op, a, rd);
    check("resp_valid", {31'h0, out_valid}, 32'h1);
    check("resp_err", {31'h0, out_err}, {31'h0, exp_err});
    check("resp_rdata", out_rdata, exp_rd);
    for (int i = 0; i < rdy_dly; i++) begin
      in_valid = 1'b1; lsu_op = 4'($urandom); addr = $urandom;
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      check("stall_valid", {31'h0, out_valid}, 32'h1);
      check("stall_rdata", out_rdata, exp_rd);
      check("stall_err", {31'h0, out_err}, {31'h0, exp_err});
      check("stall_in_ready", {31'h0, in_ready}, 32'h0);
      check("stall_no_req", {31'h0, mem_req}, 32'h0);
    end
    in_valid = 1'b0; mem_ack = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("done_valid_low", {31'h0, out_valid}, 32'h0);
    check("done_in_ready", {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    int          sel;
    int          ad;
    rst_n = 1'b0; in_valid = 1'b0; addr = '0; wdata = '0; lsu_op = '0;
    mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_rdata", out_rdata, 32'h0);
    check("rst_out_err", {31'h0, out_err}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases with spot checks against hand-computed results.
    check("t1_model", ref_load(4'b0100, 32'h80000003, 32'h80FF1234), 32'h00000080);
    access(4'b0100, 32'h80000003, 32'h0, 32'h80FF1234, 0, 0);
    check("t2_model", ref_load(4'b0001, 32'h80000002, 32'h80011234), 32'hFFFF8001);
    access(4'b0001, 32'h80000002, 32'h0, 32'h80011234, 0, 1);
    access(4'b1000, 32'h80000001, 32'h000000AB, 32'h0, 0, 0);
    access(4'b0010, 32'h80000006, 32'h0, 32'h12345678, 0, 0);
    access(4'b0011, 32'h80000000, 32'h0, 32'h12345678, 0, 0);
    access(4'b0010, 32'h80000010, 32'h0, 32'hDEADBEEF, TIMEOUT + 4, 2);
    access(4'b0010, 32'h80000020, 32'h0, 32'hCAFEF00D, TIMEOUT - 1, 0);
    access(4'b1001, 32'h80000022, 32'h0000BEEF, 32'h0, 3, 0);

    // Reset in the middle of a request; a late ack must not revive it.
    in_valid = 1'b1; lsu_op = 4'b0010; addr = 32'h80000040; wdata = 32'h0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_req", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    check("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_out_rdata", out_rdata, 32'h0);
    check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    mem_ack = 1'b0;
    check("lateack_out_valid", {31'h0, out_valid}, 32'h0);
    check("lateack_mem_req", {31'h0, mem_req}, 32'h0);
    access(4'b0000, 32'h80000045, 32'h0, 32'h00F00000, 1, 4);

    // Randomized accesses, mostly aligned, occasionally timing out.
    for (int k = 0; k < 60; k++) begin
      op  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      a   = $urandom;
      sel = $urandom_range(0, 3);
      if (sel != 0 && ref_bytes(op) != 0) a = a - (a % ref_bytes(op));
      ad  = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : $urandom_range(0, 5);
      access(op, a, $urandom, $urandom, ad, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
